// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin share of the register-file write port
// between the ALU writeback (req0) and load writeback (req1). Writes to
// register 0 are accepted but never reach the register file. A saturating
// counter records cycles in which both requesters contended.
module rf_write_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_hold,
  input  logic          i_req0_valid,
  input  logic [AW-1:0] i_req0_addr,
  input  logic [DW-1:0] i_req0_data,
  output logic          o_req0_ready,
  input  logic          i_req1_valid,
  input  logic [AW-1:0] i_req1_addr,
  input  logic [DW-1:0] i_req1_data,
  output logic          o_req1_ready,
  output logic          o_rf_we,
  output logic [AW-1:0] o_rf_waddr,
  output logic [DW-1:0] o_rf_wdata,
  output logic          o_last_grant,
  output logic [CW-1:0] o_contention_cnt
);

  logic          r_rf_we;
  logic [AW-1:0] r_rf_waddr;
  logic [DW-1:0] r_rf_wdata;
  logic          r_last_grant;
  logic [CW-1:0] r_cnt;

  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_xfer;
  logic          w_contend;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          w_cnt_max;

  // Grant: nothing under reset/hold; a lone requester wins; on a tie the
  // port that did not win last time goes.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!i_reset && !i_hold) begin
      w_gnt0 = i_req0_valid & (~i_req1_valid | r_last_grant);
      w_gnt1 = i_req1_valid & (~i_req0_valid | ~r_last_grant);
    end
  end

  assign w_xfer    = w_gnt0 | w_gnt1;
  assign w_contend = i_req0_valid & i_req1_valid & ~i_hold;
  assign w_addr    = w_gnt1 ? i_req1_addr : i_req0_addr;
  assign w_data    = w_gnt1 ? i_req1_data : i_req0_data;
  assign w_cnt_max = &r_cnt;

  // Registered write command, grant history and contention counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
    end else begin
      r_rf_we <= w_xfer && (w_addr != '0);
      // Register-0 writes are swallowed; address/data keep their old value.
      if (w_xfer && (w_addr != '0)) begin
        r_rf_waddr <= w_addr;
        r_rf_wdata <= w_data;
      end
      if (w_xfer)
        r_last_grant <= w_gnt1;
      if (w_contend && !w_cnt_max)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_req0_ready     = w_gnt0;
  assign o_req1_ready     = w_gnt1;
  assign o_rf_we          = r_rf_we;
  assign o_rf_waddr       = r_rf_waddr;
  assign o_rf_wdata       = r_rf_wdata;
  assign o_last_grant     = r_last_grant;
  assign o_contention_cnt = r_cnt;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus a randomized run,
// all checked against a transaction-level reference model. A second
// instance with a 2-bit counter exercises saturation.
module tb_rf_write_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset, hold;
  logic          v0, v1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;

  logic          rdy0, rdy1, we, lg;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [15:0]   cnt;
  logic          s_rdy0, s_rdy1, s_we, s_lg;
  logic [AW-1:0] s_waddr;
  logic [DW-1:0] s_wdata;
  logic [1:0]    s_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic          m_lg;
  int            m_cnt;

  always #5 clk = ~clk;

  rf_write_arbiter #(.AW(AW), .DW(DW), .CW(16)) dut (
    .i_clk(clk), .i_reset(reset), .i_hold(hold),
    .i_req0_valid(v0), .i_req0_addr(a0), .i_req0_data(d0), .o_req0_ready(rdy0),
    .i_req1_valid(v1), .i_req1_addr(a1), .i_req1_data(d1), .o_req1_ready(rdy1),
    .o_rf_we(we), .o_rf_waddr(waddr), .o_rf_wdata(wdata),
    .o_last_grant(lg), .o_contention_cnt(cnt));

  rf_write_arbiter #(.AW(AW), .DW(DW), .CW(2)) dut_s (
    .i_clk(clk), .i_reset(reset), .i_hold(hold),
    .i_req0_valid(v0), .i_req0_addr(a0), .i_req0_data(d0), .o_req0_ready(s_rdy0),
    .i_req1_valid(v1), .i_req1_addr(a1), .i_req1_data(d1), .o_req1_ready(s_rdy1),
    .o_rf_we(s_we), .o_rf_waddr(s_waddr), .o_rf_wdata(s_wdata),
    .o_last_grant(s_lg), .o_contention_cnt(s_cnt));

  // Expected {ready1, ready0} from the grant rules.
  function automatic logic [1:0] mgrant();
    if (reset || hold) return 2'b00;
    if (v0 && !v1)     return 2'b01;
    if (v1 && !v0)     return 2'b10;
    if (v0 && v1)      return m_lg ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [15:0] mcnt16();
    return (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
  endfunction

  function automatic logic [1:0] mcnt2();
    return (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
  endfunction

  // One clock: sample the transaction, advance the model, settle 1 time unit.
  task automatic tick();
    logic [1:0]    g;
    logic [AW-1:0] ad;
    logic [DW-1:0] dt;
    logic          cont, rs;
    g    = mgrant();
    ad   = g[1] ? a1 : a0;
    dt   = g[1] ? d1 : d0;
    cont = v0 && v1 && !hold;
    rs   = reset;
    @(posedge clk);
    #1;
    if (rs) begin
      m_we = 0; m_waddr = '0; m_wdata = '0; m_lg = 1; m_cnt = 0;
    end else begin
      m_we = (g != 2'b00) && (ad != '0);
      if (m_we) begin m_waddr = ad; m_wdata = dt; end
      if (g != 2'b00) m_lg = g[1];
      if (cont) m_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1; hold = 0; v0 = 1; v1 = 1;
    a0 = 5'd3; a1 = 5'd4; d0 = 32'h1234; d1 = 32'h5678;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({rdy1, rdy0} !== 2'b00) begin errors++;
        $display("FAIL reset_ready: got %b required 00", {rdy1, rdy0}); end
      tick();
      checks++;
      if ({we, waddr, wdata, lg, cnt} !== {1'b0, 5'd0, 32'd0, 1'b1, 16'd0}) begin errors++;
        $display("FAIL reset_state: we=%b waddr=%0d wdata=%h lg=%b cnt=%0d required 0/0/0/1/0",
                 we, waddr, wdata, lg, cnt); end
    end
    reset = 0; v0 = 0; v1 = 0;
  endtask

  task automatic test_single();
    v0 = 1; a0 = 5'd5; d0 = 32'hDEADBEEF; v1 = 0;
    #1;
    checks++;
    if ({rdy1, rdy0} !== 2'b01) begin errors++;
      $display("FAIL single_ready: got %b required 01", {rdy1, rdy0}); end
    tick();
    v0 = 0;
    checks++;
    if ({we, waddr, wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin errors++;
      $display("FAIL single_write: we=%b waddr=%0d wdata=%h required 1/5/deadbeef", we, waddr, wdata); end
    #1;
    tick();
    checks++;
    if (we !== 1'b0) begin errors++;
      $display("FAIL single_we_drop: got %b required 0", we); end
  endtask

  task automatic test_contention();
    int gexp [4] = '{0, 1, 0, 1};
    reset = 1; #1; tick(); reset = 0;
    v0 = 1; a0 = 5'd1; d0 = 32'h11;
    v1 = 1; a1 = 5'd2; d1 = 32'h22;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (rdy0 !== (gexp[k] == 0) || rdy1 !== (gexp[k] == 1)) begin errors++;
        $display("FAIL contention_grant[%0d]: got %b%b required grant %0d", k, rdy1, rdy0, gexp[k]); end
      tick();
      checks++;
      if ({we, waddr, wdata} !== {1'b1, (gexp[k] == 1) ? 5'd2 : 5'd1, (gexp[k] == 1) ? 32'h22 : 32'h11}) begin errors++;
        $display("FAIL contention_write[%0d]: we=%b waddr=%0d wdata=%h", k, we, waddr, wdata); end
    end
    checks++;
    if (cnt !== 16'd4) begin errors++;
      $display("FAIL contention_cnt: got %0d required 4", cnt); end
    v0 = 0; v1 = 0;
  endtask

  task automatic test_reg0();
    v1 = 1; a1 = 5'd0; d1 = 32'hFFFFFFFF;
    #1;
    checks++;
    if ({rdy1, rdy0} !== 2'b10) begin errors++;
      $display("FAIL reg0_ready: got %b required 10", {rdy1, rdy0}); end
    tick();
    v1 = 0;
    checks++;
    if ({we, lg} !== 2'b01) begin errors++;
      $display("FAIL reg0_write: we=%b lg=%b required we=0 lg=1", we, lg); end
  endtask

  task automatic test_hold();
    int c0;
    c0 = m_cnt;
    hold = 1; v0 = 1; a0 = 5'd7; d0 = $urandom; v1 = 1; a1 = 5'd9; d1 = $urandom;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({rdy1, rdy0} !== 2'b00) begin errors++;
        $display("FAIL hold_ready[%0d]: got %b required 00", k, {rdy1, rdy0}); end
      tick();
      checks++;
      if ({we, lg, cnt} !== {1'b0, 1'b1, 16'(c0)}) begin errors++;
        $display("FAIL hold_state[%0d]: we=%b lg=%b cnt=%0d required 0/1/%0d", k, we, lg, cnt, c0); end
    end
    hold = 0;
    #1;
    checks++;
    if ({rdy1, rdy0} !== 2'b01) begin errors++;
      $display("FAIL hold_release_ready: got %b required 01", {rdy1, rdy0}); end
    tick();
    v0 = 0;
    checks++;
    if ({we, waddr, wdata} !== {1'b1, 5'd7, d0}) begin errors++;
      $display("FAIL hold_release_write: we=%b waddr=%0d wdata=%h required 1/7/%h", we, waddr, wdata, d0); end
    #1; tick(); v1 = 0;
    checks++;
    if ({we, waddr, wdata} !== {1'b1, 5'd9, d1}) begin errors++;
      $display("FAIL hold_loser_write: we=%b waddr=%0d wdata=%h required 1/9/%h", we, waddr, wdata, d1); end
  endtask

  task automatic test_saturation();
    reset = 1; #1; tick(); reset = 0;
    v0 = 1; a0 = 5'd12; d0 = 32'hA5A5; v1 = 1; a1 = 5'd13; d1 = 32'h5A5A;
    for (int k = 0; k < 6; k++) begin
      #1; tick();
      checks++;
      if (s_cnt !== ((k + 1 > 3) ? 2'd3 : 2'(k + 1))) begin errors++;
        $display("FAIL sat_cnt[%0d]: got %0d required %0d", k, s_cnt, (k + 1 > 3) ? 3 : k + 1); end
    end
    // a write is in flight here (transfer this cycle); reset must cancel it
    reset = 1;
    #1;
    checks++;
    if ({rdy1, rdy0, s_rdy1, s_rdy0} !== 4'b0000) begin errors++;
      $display("FAIL midreset_ready: got %b required 0000", {rdy1, rdy0, s_rdy1, s_rdy0}); end
    tick();
    checks++;
    if ({we, s_we, cnt, s_cnt, lg} !== {2'b00, 16'd0, 2'd0, 1'b1}) begin errors++;
      $display("FAIL midreset_state: we=%b s_we=%b cnt=%0d s_cnt=%0d lg=%b", we, s_we, cnt, s_cnt, lg); end
    reset = 0;
    #1;
    checks++;
    if ({rdy1, rdy0} !== 2'b01) begin errors++;
      $display("FAIL post_reset_tie: got %b required 01", {rdy1, rdy0}); end
    tick();
    v0 = 0; v1 = 0;
  endtask

  task automatic test_random();
    logic [1:0] g;
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 49) == 0);
      hold  = ($urandom_range(0, 4) == 0);
      if (!v0 && $urandom_range(0, 2) != 0) begin
        v0 = 1; a0 = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom); d0 = $urandom;
      end
      if (!v1 && $urandom_range(0, 2) != 0) begin
        v1 = 1; a1 = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom); d1 = $urandom;
      end
      #1;
      g = mgrant();
      checks++;
      if ({rdy1, rdy0} !== g || {s_rdy1, s_rdy0} !== g) begin errors++;
        $display("FAIL rand_ready[%0d]: got %b/%b required %b", k, {rdy1, rdy0}, {s_rdy1, s_rdy0}, g); end
      tick();
      if (g[0]) v0 = 0;
      if (g[1]) v1 = 0;
      checks++;
      if ({we, lg, cnt, s_we, s_cnt} !== {m_we, m_lg, mcnt16(), m_we, mcnt2()} ||
          (m_we && {waddr, wdata, s_waddr, s_wdata} !== {m_waddr, m_wdata, m_waddr, m_wdata})) begin errors++;
        $display("FAIL rand_out[%0d]: we=%b lg=%b cnt=%0d s_cnt=%0d waddr=%0d wdata=%h required %b/%b/%0d/%0d/%0d/%h",
                 k, we, lg, cnt, s_cnt, waddr, wdata, m_we, m_lg, mcnt16(), mcnt2(), m_waddr, m_wdata); end
    end
    reset = 0; hold = 0; v0 = 0; v1 = 0;
  endtask

  initial begin
    m_we = 0; m_waddr = '0; m_wdata = '0; m_lg = 1; m_cnt = 0;
    reset = 1; hold = 0; v0 = 0; v1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_contention();
    test_reg0();
    test_hold();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
